// File: rtl/trig_multi.sv
// ============================================================================
// Module   : trig_multi
// Purpose  : Multi-channel wake-up trigger with synchroniser, selectable edge
//            polarity, saturating event counters and retriggerable windows.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trig_multi #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 20,
  parameter int TIM_W   = 20,
  parameter int TIMEOUT = 14000
) (
  input  logic                 clki,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       wake_up,
  input  logic [1:0]           edge_sel,
  input  logic                 retrig,
  input  logic                 clr_count,
  output logic [NCH*CNT_W-1:0] count,
  output logic [NCH-1:0]       WU_valid,
  output logic [NCH-1:0]       overrun,
  output logic                 any_valid
);

  localparam logic [1:0]       c_SEL_RISE = 2'b00;
  localparam logic [1:0]       c_SEL_FALL = 2'b01;
  localparam logic [1:0]       c_SEL_BOTH = 2'b10;
  localparam logic [TIM_W-1:0] c_TLAST    = TIM_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_CMAX     = '1;
  localparam logic [CNT_W-1:0] c_CONE     = CNT_W'(1);

  logic [NCH-1:0] w_vld_next;
  logic           any_valid_q;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [2:0]       sync_q;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [TIM_W-1:0] tmr_q, tmr_d;
      logic             vld_q, vld_d;
      logic             ovr_q, ovr_d;
      logic             w_rise, w_fall, w_edge;

      assign w_rise = ~sync_q[2] &  sync_q[1];
      assign w_fall =  sync_q[2] & ~sync_q[1];

      always_comb begin
        w_edge = 1'b0;
        case (edge_sel)
          c_SEL_RISE: w_edge = w_rise;
          c_SEL_FALL: w_edge = w_fall;
          c_SEL_BOTH: w_edge = w_rise | w_fall;
          default:    w_edge = 1'b0;
        endcase
      end

      always_comb begin
        cnt_d = cnt_q;
        tmr_d = tmr_q;
        vld_d = vld_q;
        ovr_d = ovr_q;
        if (clr_count) begin
          cnt_d = '0;
          ovr_d = 1'b0;
        end
        // Normal window progression; an edge below may override it.
        if (vld_q) begin
          if (tmr_q == c_TLAST) vld_d = 1'b0;
          else                  tmr_d = tmr_q + 1'b1;
        end
        if (w_edge) begin
          if (clr_count)             cnt_d = c_CONE;
          else if (cnt_q != c_CMAX)  cnt_d = cnt_q + 1'b1;
          if (vld_q) begin
            ovr_d = 1'b1;
            if (retrig) begin
              vld_d = 1'b1;
              tmr_d = '0;
            end
          end else begin
            vld_d = 1'b1;
            tmr_d = '0;
          end
        end
      end

      always_ff @(posedge clki) begin
        if (!rst_n) begin
          sync_q <= '0;
          cnt_q  <= '0;
          tmr_q  <= '0;
          vld_q  <= 1'b0;
          ovr_q  <= 1'b0;
        end else begin
          sync_q <= {sync_q[1:0], wake_up[i]};
          cnt_q  <= cnt_d;
          tmr_q  <= tmr_d;
          vld_q  <= vld_d;
          ovr_q  <= ovr_d;
        end
      end

      assign count[i*CNT_W +: CNT_W] = cnt_q;
      assign WU_valid[i]             = vld_q;
      assign overrun[i]              = ovr_q;
      assign w_vld_next[i]           = vld_d;
    end
  endgenerate

  // Registered from next-state so it lines up with WU_valid.
  always_ff @(posedge clki) begin
    if (!rst_n) any_valid_q <= 1'b0;
    else        any_valid_q <= |w_vld_next;
  end

  assign any_valid = any_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_trig_multi.sv
// ============================================================================
// Module   : tb_trig_multi
// Purpose  : Directed, self-checking bench for trig_multi.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trig_multi;

  localparam int NCH     = 4;
  localparam int CNT_W   = 4;
  localparam int TIM_W   = 8;
  localparam int TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       wake_up;
  logic [1:0]           edge_sel;
  logic                 retrig;
  logic                 clr_count;
  logic [NCH*CNT_W-1:0] count;
  logic [NCH-1:0]       WU_valid;
  logic [NCH-1:0]       overrun;
  logic                 any_valid;

  int checks   = 0;
  int failures = 0;

  trig_multi #(
    .NCH(NCH), .CNT_W(CNT_W), .TIM_W(TIM_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clki(clk), .rst_n(rst_n), .wake_up(wake_up), .edge_sel(edge_sel),
    .retrig(retrig), .clr_count(clr_count), .count(count),
    .WU_valid(WU_valid), .overrun(overrun), .any_valid(any_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    int         ch;
    int         len;
    logic [3:0] exp_cnt;
    logic       exp_ovr;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] cnt(input int ch);
    return count[ch*CNT_W +: CNT_W];
  endfunction

  task automatic do_reset();
    wake_up   = '0;
    clr_count = 1'b0;
    retrig    = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // First pulse high for 3 cycles; optional second rise set after tick t2.
  task automatic run_two(input int ch, input int t2, output int first, output int len);
    first = -1;
    len   = 0;
    wake_up[ch] = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      tick();
      if (WU_valid[ch]) begin
        if (first < 0) first = t;
        len++;
      end else if (first >= 0) begin
        break;
      end
      if (t == 3)      wake_up[ch] = 1'b0;
      if (t == t2)     wake_up[ch] = 1'b1;
      if (t == t2 + 2) wake_up[ch] = 1'b0;
    end
    wake_up[ch] = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   first, len;
    logic [15:0] mask;

    vecs[0] = '{2'b00, 0, 3, 4'd1, 1'b0};
    vecs[1] = '{2'b01, 1, 3, 4'd1, 1'b0};
    vecs[2] = '{2'b10, 2, 4, 4'd2, 1'b1};
    vecs[3] = '{2'b11, 3, 4, 4'd0, 1'b0};
    vecs[4] = '{2'b10, 0, 1, 4'd2, 1'b1};
    vecs[5] = '{2'b00, 3, 1, 4'd1, 1'b0};

    edge_sel = 2'b00;
    do_reset();
    check("reset_count", 32'(count), 32'h0);
    check("reset_valid", 32'(WU_valid), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_any", 32'(any_valid), 32'h0);

    // Polarity table
    foreach (vecs[k]) begin
      edge_sel = vecs[k].sel;
      do_reset();
      wake_up[vecs[k].ch] = 1'b1;
      repeat (vecs[k].len) tick();
      wake_up = '0;
      repeat (30) tick();
      mask = 16'hF << (vecs[k].ch * CNT_W);
      check($sformatf("tbl%0d_count", k), 32'(cnt(vecs[k].ch)), 32'(vecs[k].exp_cnt));
      check($sformatf("tbl%0d_overrun", k), 32'(overrun), 32'(vecs[k].exp_ovr) << vecs[k].ch);
      check($sformatf("tbl%0d_others", k), 32'(count & ~mask), 32'h0);
      check($sformatf("tbl%0d_closed", k), 32'({WU_valid, any_valid}), 32'h0);
    end

    // Latency and window length
    edge_sel = 2'b00;
    do_reset();
    wake_up[0] = 1'b1;
    tick(); tick();
    check("lat_pre_count", 32'(cnt(0)), 32'h0);
    check("lat_pre_valid", 32'(WU_valid), 32'h0);
    tick();
    check("lat_count", 32'(cnt(0)), 32'h1);
    check("lat_valid", 32'(WU_valid), 32'h1);
    check("lat_any", 32'(any_valid), 32'h1);
    do_reset();
    run_two(0, -10, first, len);
    check("win_first", 32'(first), 32'd3);
    check("win_len", 32'(len), 32'd16);
    check("win_count", 32'(count), 32'h0001);
    check("win_overrun", 32'(overrun), 32'h0);

    // Second edge 5 cycles into window, no retrigger
    do_reset();
    run_two(1, 5, first, len);
    check("noretrig_len", 32'(len), 32'd16);
    check("noretrig_count", 32'(cnt(1)), 32'h2);
    check("noretrig_overrun", 32'(overrun), 32'h2);

    // Same with retrigger
    do_reset();
    retrig = 1'b1;
    run_two(1, 5, first, len);
    check("retrig_len", 32'(len), 32'd21);
    check("retrig_count", 32'(cnt(1)), 32'h2);
    check("retrig_overrun", 32'(overrun), 32'h2);

    // Edge on the final window cycle
    do_reset();
    retrig = 1'b1;
    run_two(2, 16, first, len);
    check("last_retrig_len", 32'(len), 32'd32);
    check("last_retrig_overrun", 32'(overrun), 32'h4);
    do_reset();
    run_two(2, 16, first, len);
    check("last_noretrig_len", 32'(len), 32'd16);
    check("last_noretrig_count", 32'(cnt(2)), 32'h2);
    check("last_noretrig_overrun", 32'(overrun), 32'h4);
    // One cycle later the window is already closed
    do_reset();
    retrig = 1'b1;
    run_two(2, 17, first, len);
    check("after_close_len", 32'(len), 32'd16);
    check("after_close_count", 32'(cnt(2)), 32'h2);
    check("after_close_overrun", 32'(overrun), 32'h0);

    // Saturation and clear
    do_reset();
    retrig = 1'b1;
    for (int n = 0; n < 17; n++) begin
      wake_up[3] = 1'b1;
      tick();
      wake_up[3] = 1'b0;
      tick();
    end
    tick(); tick();
    check("sat_count", 32'(cnt(3)), 32'hF);
    check("sat_overrun", 32'(overrun), 32'h8);
    check("sat_valid", 32'(WU_valid), 32'h8);
    wake_up[3] = 1'b1;
    tick();
    wake_up[3] = 1'b0;
    tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_edge_count", 32'(cnt(3)), 32'h1);
    check("clr_edge_overrun", 32'(overrun), 32'h8);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_count", 32'(count), 32'h0);
    check("clr_overrun", 32'(overrun), 32'h0);
    check("clr_valid_kept", 32'({WU_valid, any_valid}), 32'b10001);

    // Mid-window reset, then wake_up held through reset release
    do_reset();
    wake_up = 4'hF;
    tick(); tick(); tick();
    check("all_count", 32'(count), 32'h1111);
    check("all_valid", 32'(WU_valid), 32'hF);
    wake_up = 4'h0;
    tick(); tick();
    wake_up = 4'hF;
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_outputs", 32'({count, WU_valid, overrun, any_valid}), 32'h0);
    wake_up = 4'h1;
    rst_n = 1'b1;
    tick(); tick();
    check("rel_pre_count", 32'(count), 32'h0);
    tick();
    check("rel_count", 32'(count), 32'h0001);
    check("rel_valid", 32'({WU_valid, any_valid}), 32'b00011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
